// File: rtl/debug_pkg.sv
// Shared command codes, halt marker and FSM state type for the debug command unit.
package debug_pkg;

   localparam logic [7:0]  CMD_START     = 8'h01;
   localparam logic [7:0]  CMD_CONTINUE  = 8'h02;
   localparam logic [7:0]  CMD_STEP_MODE = 8'h03;
   localparam logic [7:0]  CMD_REPROGRAM = 8'h05;
   localparam logic [7:0]  CMD_STEP      = 8'h06;

   localparam logic [31:0] HALT_MARKER   = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PROGRAM,
      ST_PROG_WRITE,
      ST_RUN,
      ST_STEP_WAIT,
      ST_STEP,
      ST_SEND
   } dbg_state_t;

endpackage

// File: rtl/debug_tx_serializer.sv
// Sends two LEN-bit words MSB first as NBITS-wide bytes, one tx_start per byte,
// advancing only on tx_done_tick.
module debug_tx_serializer #(
   parameter int LEN   = 32,
   parameter int NBITS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [LEN-1:0]   word_hi,
   input  logic [LEN-1:0]   word_lo,
   input  logic             tx_done_tick,
   output logic [NBITS-1:0] tx_data,
   output logic             tx_start,
   output logic             done
);

   localparam int NBYTES = (2 * LEN) / NBITS;
   localparam int CW     = $clog2(NBYTES + 1);

   logic [2*LEN-1:0] shreg;
   logic [CW-1:0]    remaining;
   logic             pending;

   assign tx_data  = shreg[2*LEN-1 -: NBITS];
   assign tx_start = (remaining != '0) && !pending;
   assign done     = pending && tx_done_tick && (remaining == CW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg     <= '0;
         remaining <= '0;
         pending   <= 1'b0;
      end else if (load) begin
         shreg     <= {word_hi, word_lo};
         remaining <= CW'(NBYTES);
         pending   <= 1'b0;
      end else if (tx_start) begin
         pending   <= 1'b1;
      end else if (pending && tx_done_tick) begin
         pending   <= 1'b0;
         remaining <= remaining - CW'(1);
         shreg     <= shreg << NBITS;
      end
   end

endmodule

// File: rtl/debug_command_unit.sv
// UART-driven debug controller: programs instruction memory, runs or single-steps
// the processor, and reports pc and cycle count back over the UART.
module debug_command_unit
   import debug_pkg::*;
#(
   parameter int LEN        = 32,
   parameter int NBITS      = 8,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  CLK_100MHZ,
   input  logic                  reset,
   input  logic [NBITS-1:0]      rx_data,
   input  logic                  rx_done_tick,
   input  logic                  tx_done_tick,
   input  logic                  halt,
   input  logic [LEN-1:0]        pc,
   output logic [NBITS-1:0]      tx_data,
   output logic                  tx_start,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [LEN-1:0]        mem_wr_data,
   output logic                  cpu_enable,
   output logic                  cpu_reset
);

   localparam int WBYTES = LEN / NBITS;
   localparam int BW     = (WBYTES > 1) ? $clog2(WBYTES) : 1;

   dbg_state_t     state, state_next;
   logic [LEN-1:0] cycle_cnt;
   logic [BW-1:0]  byte_idx;
   logic           from_step;
   logic           start_pulse;
   logic           ser_load;
   logic           ser_done;
   logic           cmd_start, cmd_cont, cmd_step_mode, cmd_reprog, cmd_step;

   assign cmd_start     = rx_done_tick && (rx_data == NBITS'(CMD_START));
   assign cmd_cont      = rx_done_tick && (rx_data == NBITS'(CMD_CONTINUE));
   assign cmd_step_mode = rx_done_tick && (rx_data == NBITS'(CMD_STEP_MODE));
   assign cmd_reprog    = rx_done_tick && (rx_data == NBITS'(CMD_REPROGRAM));
   assign cmd_step      = rx_done_tick && (rx_data == NBITS'(CMD_STEP));

   assign cpu_reset = start_pulse || (state == ST_PROGRAM) || (state == ST_PROG_WRITE);

   always_ff @(posedge CLK_100MHZ or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      mem_wr_en  = 1'b0;
      cpu_enable = 1'b0;
      ser_load   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_cont)           state_next = ST_RUN;
            else if (cmd_step_mode) state_next = ST_STEP_WAIT;
            else if (cmd_reprog)    state_next = ST_PROGRAM;
         end
         ST_PROGRAM: begin
            if (rx_done_tick && (byte_idx == BW'(WBYTES - 1))) state_next = ST_PROG_WRITE;
         end
         ST_PROG_WRITE: begin
            mem_wr_en = 1'b1;
            if ((mem_wr_data == LEN'(HALT_MARKER)) || (mem_addr == '1)) state_next = ST_IDLE;
            else                                                         state_next = ST_PROGRAM;
         end
         ST_RUN: begin
            // halt gates the enable combinationally so the halting cycle is not counted
            if (halt) begin
               ser_load   = 1'b1;
               state_next = ST_SEND;
            end else begin
               cpu_enable = 1'b1;
            end
         end
         ST_STEP_WAIT: begin
            if (cmd_step) state_next = ST_STEP;
         end
         ST_STEP: begin
            cpu_enable = 1'b1;
            ser_load   = 1'b1;
            state_next = ST_SEND;
         end
         ST_SEND: begin
            if (ser_done) state_next = (from_step && !halt) ? ST_STEP_WAIT : ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_100MHZ or posedge reset) begin
      if (reset) begin
         cycle_cnt   <= '0;
         mem_addr    <= '0;
         mem_wr_data <= '0;
         byte_idx    <= '0;
         from_step   <= 1'b0;
         start_pulse <= 1'b0;
      end else begin
         start_pulse <= (state == ST_IDLE) && cmd_start;
         if ((state == ST_IDLE) && cmd_start) cycle_cnt <= '0;
         else if (cpu_enable)                 cycle_cnt <= cycle_cnt + LEN'(1);
         case (state)
            ST_IDLE: begin
               if (cmd_reprog) begin
                  mem_addr    <= '0;
                  mem_wr_data <= '0;
                  byte_idx    <= '0;
               end
            end
            ST_PROGRAM: begin
               if (rx_done_tick) begin
                  mem_wr_data <= {mem_wr_data[LEN-NBITS-1:0], rx_data};
                  byte_idx    <= byte_idx + BW'(1);
               end
            end
            ST_PROG_WRITE: begin
               mem_addr <= mem_addr + ADDR_WIDTH'(1);
               byte_idx <= '0;
            end
            ST_RUN:  from_step <= 1'b0;
            ST_STEP: from_step <= 1'b1;
            default: ;
         endcase
      end
   end

   // The serializer is loaded on the transition into SEND, so the count word
   // must already include the increment of a STEP cycle.
   debug_tx_serializer #(
      .LEN   (LEN),
      .NBITS (NBITS)
   ) u_tx_serializer (
      .clk          (CLK_100MHZ),
      .rst          (reset),
      .load         (ser_load),
      .word_hi      (pc),
      .word_lo      (cycle_cnt + LEN'(cpu_enable)),
      .tx_done_tick (tx_done_tick),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .done         (ser_done)
   );

endmodule

// File: tb/tb_debug_command_unit.sv
// Randomized directed bench for debug_command_unit with a transaction-level model
// of the cycle counter, programmed words and transmitted report bytes.
`timescale 1ns/1ps
module tb_debug_command_unit;

   localparam int LEN   = 32;
   localparam int NBITS = 8;
   localparam int AW    = 10;
   localparam int MAXW  = 1 << AW;

   localparam logic [7:0]  B_START  = 8'h01;
   localparam logic [7:0]  B_CONT   = 8'h02;
   localparam logic [7:0]  B_SBS    = 8'h03;
   localparam logic [7:0]  B_REPROG = 8'h05;
   localparam logic [7:0]  B_STEP   = 8'h06;
   localparam logic [31:0] HALT_W   = 32'hFFFF_FFFF;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_done_tick;
   logic          tx_done_tick;
   logic          halt;
   logic [31:0]   pc;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic          mem_wr_en;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wr_data;
   logic          cpu_enable;
   logic          cpu_reset;
   logic [53:0]   outs;

   assign outs = {tx_data, tx_start, mem_wr_en, mem_addr, mem_wr_data, cpu_enable, cpu_reset};

   always #5 clk = ~clk;

   debug_command_unit #(
      .LEN        (LEN),
      .NBITS      (NBITS),
      .ADDR_WIDTH (AW)
   ) dut (
      .CLK_100MHZ   (clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_done_tick (rx_done_tick),
      .tx_done_tick (tx_done_tick),
      .halt         (halt),
      .pc           (pc),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .mem_wr_en    (mem_wr_en),
      .mem_addr     (mem_addr),
      .mem_wr_data  (mem_wr_data),
      .cpu_enable   (cpu_enable),
      .cpu_reset    (cpu_reset)
   );

   int unsigned   n_checks  = 0;
   int unsigned   n_pass    = 0;
   int unsigned   en_cnt    = 0;
   int unsigned   crst_cnt  = 0;
   int unsigned   excl_viol = 0;
   logic [AW-1:0] wr_addr_q[$];
   logic [31:0]   wr_data_q[$];
   logic [7:0]    tx_q[$];
   logic [31:0]   prog_q[$];
   logic [31:0]   exp_cnt = '0;

   // Passive monitor: records strobes and transmitted bytes once per cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_wr_en) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wr_data);
         end
         if (tx_start)   tx_q.push_back(tx_data);
         if (cpu_enable) en_cnt++;
         if (cpu_reset)  crst_cnt++;
         if ((32'(tx_start) + 32'(mem_wr_en) + 32'(cpu_enable)) > 32'd1) excl_viol++;
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data      = b;
      rx_done_tick = 1'b1;
      tick();
      rx_done_tick = 1'b0;
   endtask

   task automatic clear_logs();
      wr_addr_q.delete();
      wr_data_q.delete();
      tx_q.delete();
   endtask

   // Gathers one 8-byte report, answering each tx_start after 'delay' cycles.
   task automatic collect(input int unsigned delay, input bit inject, output logic [63:0] w);
      int base;
      int t;
      base = tx_q.size();
      w    = '0;
      for (int k = 0; k < 8; k++) begin
         t = 0;
         while (tx_q.size() <= base + k && t < 300) begin
            tick();
            t++;
         end
         if (tx_q.size() <= base + k) begin
            check("tx_byte_timeout", 64'(tx_q.size() - base), 64'(k + 1));
            return;
         end
         w = {w[55:0], tx_q[base + k]};
         if (k == 0) pc = $urandom;
         if (inject && k == 2) send_byte(B_STEP);
         repeat (delay) tick();
         if (delay >= 100) check("tx_wait_hold", 64'(tx_q.size() - base), 64'(k + 1));
         tx_done_tick = 1'b1;
         tick();
         tx_done_tick = 1'b0;
      end
   endtask

   task automatic run_cont(input int unsigned n, input logic [31:0] pcv,
                           input int unsigned delay, output logic [63:0] w);
      send_byte(B_CONT);
      repeat (n) tick();
      pc      = pcv;
      halt    = 1'b1;
      exp_cnt = exp_cnt + 32'(n);
      collect(delay, 1'b0, w);
      halt = 1'b0;
      tick();
   endtask

   task automatic do_step(input logic [31:0] pcv, input logic hv, input int unsigned delay,
                          input bit inject, output logic [63:0] w);
      pc   = pcv;
      halt = hv;
      send_byte(B_STEP);
      exp_cnt = exp_cnt + 32'd1;
      collect(delay, inject, w);
      halt = 1'b0;
      tick();
   endtask

   task automatic program_q();
      logic [31:0] wd;
      send_byte(B_REPROG);
      tick();
      check("prog_crst_hi", 64'(cpu_reset), 64'd1);
      for (int i = 0; i < prog_q.size(); i++) begin
         wd = prog_q[i];
         for (int b = 3; b >= 0; b--) begin
            send_byte(wd[b*8 +: 8]);
            tick();
         end
      end
      tick();
   endtask

   task automatic check_writes();
      int n_exp;
      int bad;
      n_exp = 0;
      bad   = 0;
      for (int i = 0; i < prog_q.size(); i++) begin
         n_exp++;
         if (prog_q[i] == HALT_W || i == MAXW - 1) break;
      end
      check("wr_count", 64'(wr_addr_q.size()), 64'(n_exp));
      for (int i = 0; i < n_exp && i < wr_addr_q.size(); i++)
         if ({wr_addr_q[i], wr_data_q[i]} !== {AW'(i), prog_q[i]}) bad++;
      check("wr_contents_bad", 64'(bad), 64'd0);
   endtask

   initial begin
      logic [63:0] w;
      logic [31:0] pv;
      logic [31:0] wd;
      int unsigned n;
      int unsigned e0;
      int unsigned c0;
      int          t0;
      int          w0;
      int          tmo;

      rx_data      = '0;
      rx_done_tick = 1'b0;
      tx_done_tick = 1'b0;
      halt         = 1'b0;
      pc           = '0;
      reset        = 1'b0;
      #1 reset = 1'b1;
      #1 check("reset_outputs", 64'(outs), 64'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      tick();

      c0 = crst_cnt;
      send_byte(B_START);
      repeat (3) tick();
      check("start_crst_pulse", 64'(crst_cnt - c0), 64'd1);
      exp_cnt = '0;

      clear_logs();
      prog_q = '{32'h2008_0005, HALT_W};
      program_q();
      check("prog_wr_count", 64'(wr_addr_q.size()), 64'd2);
      if (wr_addr_q.size() >= 2) begin
         check("prog_wr0", {22'd0, wr_addr_q[0], wr_data_q[0]}, {22'd0, 10'd0, 32'h2008_0005});
         check("prog_wr1", {22'd0, wr_addr_q[1], wr_data_q[1]}, {22'd0, 10'd1, 32'hFFFF_FFFF});
      end
      check("prog_done_crst_low", 64'(cpu_reset), 64'd0);

      clear_logs();
      prog_q.delete();
      for (int i = 0; i < 3; i++) begin
         wd = $urandom;
         if (wd == HALT_W) wd = 32'h0;
         prog_q.push_back(wd);
      end
      prog_q.push_back(HALT_W);
      prog_q.push_back(32'h1234_5678);
      program_q();
      check_writes();

      send_byte(B_START);
      tick();
      exp_cnt = '0;
      send_byte(B_SBS);
      tick();
      e0 = en_cnt;
      do_step(32'h4, 1'b0, 1, 1'b0, w);
      check("step_bytes", w, 64'h0000_0004_0000_0001);
      check("step_en_one", 64'(en_cnt - e0), 64'd1);
      e0 = en_cnt;
      t0 = tx_q.size();
      pv = $urandom;
      do_step(pv, 1'b0, 2, 1'b1, w);
      check("step_inject_bytes", w, {pv, exp_cnt});
      repeat (10) tick();
      check("step_inject_en", 64'(en_cnt - e0), 64'd1);
      check("step_inject_tx", 64'(tx_q.size() - t0), 64'd8);
      pv = $urandom;
      do_step(pv, 1'b1, 0, 1'b0, w);
      check("step_halt_bytes", w, {pv, exp_cnt});

      e0 = en_cnt;
      t0 = tx_q.size();
      w0 = wr_addr_q.size();
      c0 = crst_cnt;
      send_byte(B_STEP);
      tick();
      send_byte(8'h07);
      tick();
      tx_done_tick = 1'b1;
      tick();
      tx_done_tick = 1'b0;
      repeat (5) tick();
      check("idle_ignored", {8'(en_cnt - e0), 8'(tx_q.size() - t0), 8'(wr_addr_q.size() - w0), 8'(crst_cnt - c0)}, 64'd0);

      send_byte(B_START);
      tick();
      exp_cnt = '0;
      e0 = en_cnt;
      run_cont(10, 32'h28, 2, w);
      check("run_bytes", w, 64'h0000_0028_0000_000A);
      check("run_en_count", 64'(en_cnt - e0), 64'd10);

      for (int it = 0; it < 6; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            send_byte(B_START);
            tick();
            exp_cnt = '0;
         end
         if ($urandom_range(0, 1) == 0) begin
            n  = $urandom_range(1, 20);
            pv = $urandom;
            e0 = en_cnt;
            run_cont(n, pv, $urandom_range(0, 3), w);
            check("rnd_run_bytes", w, {pv, exp_cnt});
            check("rnd_run_en", 64'(en_cnt - e0), 64'(n));
         end else begin
            n = $urandom_range(1, 3);
            send_byte(B_SBS);
            tick();
            for (int j = 0; j < int'(n); j++) begin
               pv = $urandom;
               do_step(pv, (j == int'(n) - 1), $urandom_range(0, 3), ($urandom_range(0, 1) == 1), w);
               check("rnd_step_bytes", w, {pv, exp_cnt});
            end
         end
      end

      pv = $urandom;
      run_cont(3, pv, 100, w);
      check("slow_tx_bytes", w, {pv, exp_cnt});

      send_byte(B_REPROG);
      tick();
      send_byte(8'hAB);
      tick();
      send_byte(8'hCD);
      tick();
      check("midprog_crst_hi", 64'(cpu_reset), 64'd1);
      #2 reset = 1'b1;
      #1 check("async_rst_prog", 64'(outs), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      tick();
      clear_logs();
      exp_cnt = '0;
      wd = $urandom;
      if (wd == HALT_W) wd = 32'h0BAD_F00D;
      prog_q = '{wd, HALT_W};
      program_q();
      check_writes();

      send_byte(B_CONT);
      repeat (4) tick();
      pc   = 32'hA5C3_0001;
      halt = 1'b1;
      t0   = tx_q.size();
      tmo  = 0;
      while (tx_q.size() == t0 && tmo < 50) begin
         tick();
         tmo++;
      end
      check("send_started", 64'(tx_q.size() - t0), 64'd1);
      #2 reset = 1'b1;
      #1 check("async_rst_send", 64'(outs), 64'd0);
      halt = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      tick();
      clear_logs();
      exp_cnt = '0;
      send_byte(B_SBS);
      tick();
      pv = $urandom;
      do_step(pv, 1'b0, 0, 1'b0, w);
      check("post_rst_step", w, {pv, 32'd1});
      pv = $urandom;
      do_step(pv, 1'b1, 1, 1'b0, w);
      check("post_rst_step2", w, {pv, exp_cnt});

      clear_logs();
      prog_q.delete();
      for (int i = 0; i < MAXW; i++) begin
         wd = $urandom;
         if (wd == HALT_W) wd = 32'h0;
         prog_q.push_back(wd);
      end
      program_q();
      check_writes();
      check("limit_crst_low", 64'(cpu_reset), 64'd0);

      check("outputs_exclusive", 64'(excl_viol), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/debug_command_unit.md
DEBUG_COMMAND_UNIT -- requirements
Module: debug_command_unit

Interface
REQ-001 Parameter LEN, default 32, processor data/PC width in bits.
REQ-002 Parameter NBITS, default 8, UART byte width.
REQ-003 Parameter ADDR_WIDTH, default 10, instruction-memory word-address width.
REQ-004 CLK_100MHZ  input  1  one clock; all state on rising edge.
REQ-005 reset  input  1  reset is asynchronous and active-high.
REQ-006 rx_data  input  NBITS  byte from UART receiver, valid while rx_done_tick=1.
REQ-007 rx_done_tick  input  1  one-cycle pulse: new received byte.
REQ-008 tx_done_tick  input  1  one-cycle pulse: UART transmitter finished current byte.
REQ-009 halt  input  1  processor executed halt instruction.
REQ-010 pc  input  LEN  processor program counter.
REQ-011 tx_data  output  NBITS  byte to transmit.
REQ-012 tx_start  output  1  one-cycle request to transmit tx_data.
REQ-013 mem_wr_en  output  1  instruction-memory write strobe.
REQ-014 mem_addr  output  ADDR_WIDTH  instruction-memory word address.
REQ-015 mem_wr_data  output  LEN  instruction word to write.
REQ-016 cpu_enable  output  1  processor advances one cycle per high clock.
REQ-017 cpu_reset  output  1  synchronous reset request to processor pipeline.

Function
REQ-018 Commands: Start=8'h01, Continuous=8'h02, StepByStep=8'h03, ReProgram=8'h05, Step=8'h06; halt marker word = 32'hFFFFFFFF.
REQ-019 States: IDLE, PROGRAM, PROG_WRITE, RUN, STEP_WAIT, STEP, SEND; reset state IDLE.
REQ-020 IDLE: byte Start -> cpu_reset high one cycle, cycle counter cleared, stay IDLE; Continuous -> RUN; StepByStep -> STEP_WAIT; ReProgram -> PROGRAM with mem_addr=0 and cpu_reset held high; other bytes ignored.
REQ-021 PROGRAM: collect 4 bytes MSB first into shift register; after 4th byte -> PROG_WRITE.
REQ-022 PROG_WRITE: mem_wr_en high exactly one cycle with current mem_addr/mem_wr_data; then mem_addr increments; word equal to halt marker, or mem_addr at 2^ADDR_WIDTH-1, -> IDLE (cpu_reset released), else -> PROGRAM.
REQ-023 RUN: cpu_enable high every cycle; cycle counter increments per enabled cycle; halt=1 -> cpu_enable low same cycle the transition registers, -> SEND; rx bytes ignored.
REQ-024 STEP_WAIT: cpu_enable low; byte Step -> STEP; other bytes ignored.
REQ-025 STEP: cpu_enable high exactly one cycle, counter increments by 1, -> SEND.
REQ-026 SEND: transmit 8 bytes: pc then cycle counter, each MSB first; tx_start high one cycle per byte, next byte only after tx_done_tick; rx bytes ignored.
REQ-027 After SEND: came from RUN -> IDLE; from STEP -> IDLE if halt=1, else STEP_WAIT.
REQ-028 Values sent are latched on SEND entry; pc changes during SEND do not alter transmitted bytes.
REQ-029 Cycle counter is LEN bits, wraps modulo 2^LEN.
REQ-030 tx_done_tick outside SEND, and rx_done_tick while a tx byte is pending, are ignored without state change.
REQ-031 tx_start, mem_wr_en, cpu_enable never high in same cycle as each other.

Reset
REQ-032 On reset assertion, immediately: state IDLE, all outputs 0 (tx_data=0, mem_addr=0, mem_wr_data=0), counters/byte index cleared, including mid-PROGRAM or mid-SEND; partial words discarded.

Structure
REQ-033 Command codes, halt marker, and state encoding constants live in shared package debug_pkg.
REQ-034 Byte serializer (load LEN-bit words, tx_start/tx_done_tick pacing) is one sub-module debug_tx_serializer; remainder is single FSM.

Verification
REQ-035 ReProgram, bytes 20 08 00 05, FF FF FF FF -> mem_wr_en pulses at addr 0 data 32'h20080005, addr 1 data 32'hFFFFFFFF, then IDLE, cpu_reset low.
REQ-036 StepByStep, then Step with pc=32'h4 -> cpu_enable high one cycle, tx bytes 00 00 00 04 00 00 00 01, back to STEP_WAIT.
REQ-037 Continuous, halt raised after 10 enabled cycles, pc=32'h28 -> tx bytes 00 00 00 28 00 00 00 0A, then IDLE.
REQ-038 Step byte received during SEND, and byte 8'h07 in IDLE -> ignored, no cpu_enable pulse, state unchanged.
REQ-039 reset asserted after 2nd program byte -> all outputs 0 asynchronously; next ReProgram writes addr 0 with fresh 4 bytes.
REQ-040 tx_done_tick withheld 100 cycles -> tx_start stays low, no byte skipped.
